// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern transmitter: loads up to WIDTH bits and shifts them
// out MSB-first on x, one bit per clock, with valid/busy/done handshakes.
module serial_pattern_tx #(
    parameter int          WIDTH      = 16,
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter int          CNT_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bits_sent
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic [CNT_W-1:0] rem_q,     rem_d;
    logic [CNT_W-1:0] bits_q,    bits_d;
    logic             x_q,       x_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [CNT_W-1:0] eff_len_s;
    logic [CNT_W-1:0] shamt_s;
    logic [WIDTH-1:0] aligned_s;
    logic [WIDTH-1:0] shifted_s;

    // Payload is left-justified so the bit to transmit is always shreg[WIDTH-1].
    always_comb begin
        eff_len_s = (len > WIDTH_C) ? WIDTH_C : len;
        shamt_s   = WIDTH_C - eff_len_s;
        aligned_s = data << shamt_s;
        shifted_s = shreg_q << 1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        rem_d   = rem_q;
        bits_d  = bits_q;
        x_d     = x_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (len != {CNT_W{1'b0}})) begin
                    shreg_d = aligned_s;
                    rem_d   = eff_len_s;
                    bits_d  = {CNT_W{1'b0}};
                    x_d     = aligned_s[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                // Abort outranks retirement: the bit on x is dropped uncounted.
                if (abort) begin
                    x_d     = IDLE_LEVEL;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    rem_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else if (rem_q == CNT_W'(1)) begin
                    bits_d  = bits_q + CNT_W'(1);
                    rem_d   = {CNT_W{1'b0}};
                    shreg_d = shifted_s;
                    x_d     = IDLE_LEVEL;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    bits_d  = bits_q + CNT_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    shreg_d = shifted_s;
                    x_d     = shifted_s[WIDTH-1];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = IDLE_LEVEL;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= {WIDTH{1'b0}};
            rem_q   <= {CNT_W{1'b0}};
            bits_q  <= {CNT_W{1'b0}};
            x_q     <= IDLE_LEVEL;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            bits_q  <= bits_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x         = x_q;
    assign x_valid   = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bits_sent = bits_q;

endmodule
